// File: rtl/al_accel_quant_lut_seq_if.sv
// al_accel_quant_lut_seq_if
//   Bundles the load/status and read-port signals of the quantisation multiple table.
//   master: config/quantiser side (drives load, multiplier and read requests)
//   slave : the table (drives status and read data)
//   Signals:
//     quant_load  - single-cycle request to latch quant_muler and rebuild the table
//     quant_muler - multiplier M (MUL_W bits)
//     signed_mode - 1 = sign-extend M, 0 = zero-extend M
//     lut_busy    - build in progress
//     lut_ready   - table fully valid
//     rd_en       - per-port read request (NUM_RD bits)
//     rd_idx      - per-port index, port i at [i*IDX_W +: IDX_W]
//     rd_val      - per-port read data, port i at [i*OUT_W +: OUT_W]
//     rd_vld      - per-port read-data valid
interface al_accel_quant_lut_seq_if #(
   parameter int unsigned MUL_W  = 32,
   parameter int unsigned OUT_W  = 64,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned NUM_RD = 4
);
   logic                      quant_load;
   logic [MUL_W-1:0]          quant_muler;
   logic                      signed_mode;
   logic                      lut_busy;
   logic                      lut_ready;
   logic [NUM_RD-1:0]         rd_en;
   logic [NUM_RD*IDX_W-1:0]   rd_idx;
   logic [NUM_RD*OUT_W-1:0]   rd_val;
   logic [NUM_RD-1:0]         rd_vld;

   modport master (
      output quant_load, quant_muler, signed_mode, rd_en, rd_idx,
      input  lut_busy, lut_ready, rd_val, rd_vld
   );

   modport slave (
      input  quant_load, quant_muler, signed_mode, rd_en, rd_idx,
      output lut_busy, lut_ready, rd_val, rd_vld
   );
endinterface

// File: rtl/al_accel_quant_lut_seq.sv
// al_accel_quant_lut_seq
//   Registered quantisation multiple table. A load latches multiplier M (sign- or
//   zero-extended to OUT_W) and builds entry[k] = k*M (mod 2^OUT_W) for k = 0..2^IDX_W-1,
//   one entry per cycle with an accumulator. NUM_RD independent registered read ports
//   serve the table with one cycle of latency.
//   Ports:
//     clk    - clock
//     resetn - synchronous active-low reset (overrides enb)
//     enb    - global enable; when low every register holds
//     bus    - slave side of al_accel_quant_lut_seq_if (load, status, read ports)
module al_accel_quant_lut_seq #(
   parameter int unsigned MUL_W  = 32,
   parameter int unsigned OUT_W  = 64,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned NUM_RD = 4
) (
   input logic                    clk,
   input logic                    resetn,
   input logic                    enb,
   al_accel_quant_lut_seq_if.slave bus
);

   localparam int N = 1 << IDX_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUILD = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   logic [1:0]              state_q, state_d;
   logic [OUT_W-1:0]        mx_q, mx_d;
   logic [OUT_W-1:0]        acc_q, acc_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic [OUT_W-1:0]        entry_q [N];
   logic [OUT_W-1:0]        entry_d [N];
   logic [NUM_RD*OUT_W-1:0] rd_val_q, rd_val_d;
   logic [NUM_RD-1:0]       rd_vld_q, rd_vld_d;

   logic [OUT_W-1:0]        m_ext;
   logic [OUT_W-1:0]        acc_sum;

   // Extension bits replicate the MSB only in signed mode.
   assign m_ext   = {{(OUT_W-MUL_W){bus.quant_muler[MUL_W-1] & bus.signed_mode}},
                     bus.quant_muler};
   assign acc_sum = acc_q + mx_q;

   always_comb begin
      state_d  = state_q;
      mx_d     = mx_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      entry_d  = entry_q;
      rd_val_d = rd_val_q;
      rd_vld_d = rd_vld_q;

      if (enb) begin
         // Reads see the table as stored before this edge's build write.
         for (int i = 0; i < int'(NUM_RD); i++) begin
            rd_vld_d[i] = bus.rd_en[i] & (state_q == ST_READY);
            if (bus.rd_en[i]) begin
               rd_val_d[i*OUT_W +: OUT_W] = entry_q[bus.rd_idx[i*IDX_W +: IDX_W]];
            end
         end

         // A load takes priority over a build step on the same edge.
         if (bus.quant_load) begin
            mx_d       = m_ext;
            acc_d      = '0;
            cnt_d      = IDX_W'(1);
            entry_d[0] = '0;
            state_d    = ST_BUILD;
         end else if (state_q == ST_BUILD) begin
            entry_d[cnt_q] = acc_sum;
            acc_d          = acc_sum;
            cnt_d          = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(N-1)) begin
               state_d = ST_READY;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         mx_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         rd_val_q <= '0;
         rd_vld_q <= '0;
         for (int k = 0; k < N; k++) begin
            entry_q[k] <= '0;
         end
      end else begin
         state_q  <= state_d;
         mx_q     <= mx_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         rd_val_q <= rd_val_d;
         rd_vld_q <= rd_vld_d;
         for (int k = 0; k < N; k++) begin
            entry_q[k] <= entry_d[k];
         end
      end
   end

   assign bus.lut_busy  = (state_q == ST_BUILD);
   assign bus.lut_ready = (state_q == ST_READY);
   assign bus.rd_val    = rd_val_q;
   assign bus.rd_vld    = rd_vld_q;

endmodule

// File: tb/tb_al_accel_quant_lut_seq.sv
// Scoreboard bench for al_accel_quant_lut_seq: the driver steps a k*M reference model
// on every clock edge and queues the expected read results; an independent monitor
// pops them whenever the DUT presents valid read data.
module tb_al_accel_quant_lut_seq;
   localparam int unsigned MUL_W  = 32;
   localparam int unsigned OUT_W  = 64;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned NUM_RD = 4;
   localparam int          N      = 16;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic enb = 1'b1;
   always #5 clk = ~clk;

   al_accel_quant_lut_seq_if #(.MUL_W(MUL_W), .OUT_W(OUT_W), .IDX_W(IDX_W),
                               .NUM_RD(NUM_RD)) bus ();

   al_accel_quant_lut_seq #(.MUL_W(MUL_W), .OUT_W(OUT_W), .IDX_W(IDX_W),
                            .NUM_RD(NUM_RD)) dut (
      .clk    (clk),
      .resetn (resetn),
      .enb    (enb),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [NUM_RD-1:0]       vld;
      logic [NUM_RD*OUT_W-1:0] val;
   } exp_t;
   exp_t sb_q[$];

   // Reference model: table contents as k*M, build progress as an integer k.
   logic [OUT_W-1:0]        tbl [N];
   logic [OUT_W-1:0]        m_mx = '0;
   int                      m_k = 0;
   bit                      m_build = 0;
   bit                      m_ready = 0;
   logic [NUM_RD*OUT_W-1:0] m_val = '0;

   task automatic chk(input string name, input logic [OUT_W-1:0] act,
                      input logic [OUT_W-1:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic model_step();
      logic [NUM_RD-1:0]       nvld;
      logic [NUM_RD*OUT_W-1:0] nval;
      logic [MUL_W-1:0]        m;
      if (!resetn) begin
         foreach (tbl[k]) tbl[k] = '0;
         m_build = 0;
         m_ready = 0;
         m_val   = '0;
         m_k     = 0;
      end else if (enb) begin
         nval = m_val;
         for (int i = 0; i < int'(NUM_RD); i++) begin
            nvld[i] = bus.rd_en[i] && m_ready;
            if (bus.rd_en[i]) nval[i*OUT_W +: OUT_W] = tbl[bus.rd_idx[i*IDX_W +: IDX_W]];
         end
         if (bus.quant_load) begin
            m = bus.quant_muler;
            m_mx    = bus.signed_mode ? OUT_W'($signed(m)) : OUT_W'(m);
            m_k     = 1;
            m_build = 1;
            m_ready = 0;
         end else if (m_build) begin
            tbl[m_k] = OUT_W'(m_k) * m_mx;
            if (m_k == N - 1) begin
               m_build = 0;
               m_ready = 1;
            end
            m_k++;
         end
         m_val = nval;
         if (|nvld) sb_q.push_back('{vld: nvld, val: nval});
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // Monitor: status every cycle; read data whenever a fresh valid appears.
   initial begin
      bit   live;
      exp_t e;
      forever begin
         @(posedge clk);
         live = resetn && enb;
         @(negedge clk);
         chk("lut_busy", 64'(bus.lut_busy), 64'(m_build));
         chk("lut_ready", 64'(bus.lut_ready), 64'(m_ready));
         if (live && |bus.rd_vld) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_rd_vld", 64'(bus.rd_vld), 64'(0));
            end else begin
               e = sb_q.pop_front();
               chk("sb_rd_vld", 64'(bus.rd_vld), 64'(e.vld));
               for (int i = 0; i < int'(NUM_RD); i++) begin
                  chk($sformatf("sb_rd_val%0d", i), bus.rd_val[i*OUT_W +: OUT_W],
                      e.val[i*OUT_W +: OUT_W]);
               end
            end
         end
      end
   end

   task automatic load(input logic [MUL_W-1:0] m, input bit s);
      bus.quant_load  = 1'b1;
      bus.quant_muler = m;
      bus.signed_mode = s;
      step();
      bus.quant_load  = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      while (!bus.lut_ready && cyc < 200) begin
         step();
         cyc++;
      end
      if (!bus.lut_ready) chk("ready_timeout", 64'(bus.lut_ready), 64'(1));
   endtask

   task automatic rd(input logic [NUM_RD-1:0] en, input logic [NUM_RD*IDX_W-1:0] idx);
      bus.rd_en  = en;
      bus.rd_idx = idx;
      step();
      bus.rd_en  = '0;
   endtask

   initial begin
      int cyc;
      bus.quant_load  = 1'b0;
      bus.quant_muler = '0;
      bus.signed_mode = 1'b0;
      bus.rd_en       = '0;
      bus.rd_idx      = '0;
      resetn = 1'b0;
      repeat (3) step();
      chk("rst_busy", 64'(bus.lut_busy), 64'(0));
      chk("rst_ready", 64'(bus.lut_ready), 64'(0));
      chk("rst_vld", 64'(bus.rd_vld), 64'(0));
      for (int i = 0; i < int'(NUM_RD); i++) chk("rst_val", bus.rd_val[i*OUT_W +: OUT_W], 0);
      resetn = 1'b1;
      step();

      // M=3 unsigned: busy lasts 15 cycles, entry 15 = 45.
      load(32'd3, 1'b0);
      chk("m3_busy_after_load", 64'(bus.lut_busy), 64'(1));
      wait_ready(cyc);
      chk("m3_busy_cycles", 64'(cyc), 64'(15));
      rd(4'b0001, 16'h000f);
      chk("m3_idx15", bus.rd_val[63:0], 64'd45);
      chk("m3_vld", 64'(bus.rd_vld), 64'(4'b0001));

      // All-ones multiplier, unsigned then signed.
      load(32'hffff_ffff, 1'b0);
      wait_ready(cyc);
      rd(4'b0001, 16'h000f);
      chk("ff_uns_idx15", bus.rd_val[63:0], 64'h0000_000e_ffff_fff1);
      load(32'hffff_ffff, 1'b1);
      wait_ready(cyc);
      rd(4'b0011, 16'h001f);
      chk("ff_sgn_idx15", bus.rd_val[63:0], 64'hffff_ffff_ffff_fff1);
      chk("ff_sgn_idx1", bus.rd_val[127:64], 64'hffff_ffff_ffff_ffff);

      // Reload mid-build: M=5 then M=7 at build cycle 6.
      load(32'd5, 1'b0);
      repeat (5) step();
      load(32'd7, 1'b0);
      wait_ready(cyc);
      chk("reload_ready_cycles", 64'(cyc), 64'(15));
      for (int k = 0; k < N; k += 4) begin
         rd(4'b1111, {4'(k + 3), 4'(k + 2), 4'(k + 1), 4'(k)});
         for (int i = 0; i < 4; i++)
            chk($sformatf("reload_idx%0d", k + i), bus.rd_val[i*OUT_W +: OUT_W],
                64'(7 * (k + i)));
      end

      // Enable stall of 10 cycles mid-build.
      load(32'd2, 1'b0);
      repeat (4) step();
      enb = 1'b0;
      repeat (10) step();
      chk("stall_busy_frozen", 64'(bus.lut_busy), 64'(1));
      enb = 1'b1;
      wait_ready(cyc);
      chk("stall_total_cycles", 64'(cyc + 14), 64'(25));
      rd(4'b0001, 16'h000f);
      chk("stall_idx15", bus.rd_val[63:0], 64'd30);

      // Four ports, shared indices.
      load(32'd9, 1'b0);
      wait_ready(cyc);
      rd(4'b1111, 16'hff10);
      chk("m9_p0", bus.rd_val[63:0], 64'd0);
      chk("m9_p1", bus.rd_val[127:64], 64'd9);
      chk("m9_p2", bus.rd_val[191:128], 64'd135);
      chk("m9_p3", bus.rd_val[255:192], 64'd135);
      chk("m9_vld", 64'(bus.rd_vld), 64'(4'b1111));
      load(32'd9, 1'b0);
      step();
      rd(4'b1111, 16'hff10);
      chk("rebuild_vld", 64'(bus.rd_vld), 64'(0));
      wait_ready(cyc);

      // Randomised traffic against the model.
      for (int c = 0; c < 400; c++) begin
         enb             = ($urandom % 8) != 0;
         bus.quant_load  = ($urandom % 30) == 0;
         bus.quant_muler = $urandom;
         bus.signed_mode = $urandom % 2;
         bus.rd_en       = 4'($urandom);
         bus.rd_idx      = 16'($urandom);
         step();
      end
      enb = 1'b1;
      bus.quant_load = 1'b0;
      bus.rd_en = '0;

      // Reset in the middle of a build.
      load(32'd11, 1'b0);
      repeat (3) step();
      resetn = 1'b0;
      step();
      chk("midrst_busy", 64'(bus.lut_busy), 64'(0));
      chk("midrst_ready", 64'(bus.lut_ready), 64'(0));
      for (int i = 0; i < int'(NUM_RD); i++)
         chk("midrst_val", bus.rd_val[i*OUT_W +: OUT_W], 64'd0);
      resetn = 1'b1;
      rd(4'b0001, 16'h000f);
      chk("postrst_idx15", bus.rd_val[63:0], 64'd0);
      chk("postrst_vld", 64'(bus.rd_vld), 64'(0));

      repeat (3) step();
      chk("sb_drained", 64'(sb_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/al_accel_quant_lut_seq.md
Name: al_accel_quant_lut_seq

Overview:
Registered, parametrised successor to the combinational quantisation multiple table. On a load request it latches a quantisation multiplier M and builds a table of multiples k*M, for k = 0..2^IDX_W-1, one entry per cycle using an accumulator. The table then serves NUM_RD independent registered read ports to the quantisation datapath. It sits between the accelerator config registers (source of M) and the per-lane quantisers.

Parameters:
MUL_W, 32, width of quant_muler input
OUT_W, 64, width of each table entry and read value; must be >= MUL_W + IDX_W
IDX_W, 4, index width; table depth N = 2^IDX_W
NUM_RD, 4, number of independent read ports

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
enb  in  1  global enable; when low, all state (including build progress) freezes
quant_load  in  1  single-cycle request to latch quant_muler and (re)build the table
quant_muler  in  MUL_W  multiplier M, sampled on an accepted load
signed_mode  in  1  sampled with M: 1 = sign-extend M to OUT_W, 0 = zero-extend
lut_busy  out  1  table build in progress
lut_ready  out  1  table fully valid
rd_en  in  NUM_RD  per-port read request
rd_idx  in  NUM_RD*IDX_W  per-port index; port i uses bits [i*IDX_W +: IDX_W]
rd_val  out  NUM_RD*OUT_W  per-port read data; port i uses bits [i*OUT_W +: OUT_W]
rd_vld  out  NUM_RD  per-port read-data valid

Behaviour:
- Reset (resetn=0 at posedge): all table entries=0, accumulator=0, state=IDLE, lut_busy=0, lut_ready=0, rd_val=0, rd_vld=0. Reset overrides enb and any in-flight build.
- The design is synchronous only. A posedge with enb=0 changes nothing, except that reset still applies.
- States:
  - IDLE: table invalid.
  - BUILD: table being written.
  - READY: table valid.
- Load acceptance: quant_load=1 with enb=1 is accepted in any state.
  - Latch Mx = M extended to OUT_W per signed_mode.
  - Set entry[0]=0, accumulator=0, count=1, state=BUILD.
- BUILD cycle (enb=1): acc_next = acc + Mx (mod 2^OUT_W); entry[count] <= acc_next; acc <= acc_next; count++.
  - When count == N-1 is written, next state is READY.
- Latency: if the load is accepted at edge t (no stalls), entries 1..N-1 are written at edges t+1..t+N-1. lut_busy=1 from t through t+N-1, and lut_ready=1 from t+N-1 on. For N=16: 15 build edges.
- Reload during BUILD: restarts the build from count=1 with the new M. Old partial contents of entries >= 1 are overwritten progressively.
- Reload during READY: lut_ready drops after the load edge; the sequence is the same as from IDLE.
- Load and build on the same edge: load wins.
- Arithmetic is modulo 2^OUT_W, with no saturation. In signed mode, entries are two's-complement k*M.
- Reads (enb=1): rd_val[i] <= entry[rd_idx[i]] and rd_vld[i] <= rd_en[i] & lut_ready, both with 1-cycle latency.
  - rd_en=0 holds rd_val[i] and clears rd_vld[i].
  - Reads during BUILD return current stored contents with rd_vld=0.
  - Ports are fully independent; any number may address the same index in the same cycle.
- rd_idx=0 always returns 0 after reset or any load.

Test Plan:
- Reset, then load M=3 unsigned; read idx 15 after lut_ready -> rd_val=45, rd_vld=1 one cycle after rd_en. Measured lut_busy duration = 15 cycles.
- Load M=0xFFFFFFFF, signed_mode=0 -> entry15 = 0x0000000EFFFFFFF1. Load the same M with signed_mode=1 -> entry15 = 0xFFFFFFFFFFFFFFF1, entry1 = 0xFFFFFFFFFFFFFFFF.
- Load M=5, then at build cycle 6 load M=7 -> lut_ready asserts 15 cycles after the second load; entry k = 7k for all k, with no residual 5k values.
- Load M=2, drive enb=0 for 10 cycles mid-build -> build count, state and outputs frozen; lut_ready arrives exactly 10 cycles late; final entry15=30.
- With READY table M=9, all 4 ports read idx {0,1,15,15} simultaneously -> {0,9,135,135}, all rd_vld=1. During a rebuild the same reads give rd_vld=0.
- Assert resetn=0 mid-build -> next cycle lut_busy=0, lut_ready=0, rd_val=0; a subsequent read of idx 15 returns 0 with rd_vld=0.
